// File: rtl/cmp_scan_pkg.sv
// Shared types and default constants for the comparator scan sequencer.
package cmp_scan_pkg;

    localparam int CMP_N_CODES = 4;
    localparam int CMP_SETTLE  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/cmp_settle_timer.sv
// Loadable settle down-counter; expire flags the last settle cycle (count == 1).
module cmp_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int TW = $clog2(SETTLE + 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = TW'(SETTLE);
        end else if (en && (count_q != '0)) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == TW'(1));

endmodule

// File: rtl/cmp_scan_ctrl.sv
// Sweeps the comparator select through every code, samples cmp_in after a settle
// time and scores each sample against a latched membership mask.
module cmp_scan_ctrl
    import cmp_scan_pkg::*;
#(
    parameter int N_CODES = CMP_N_CODES,
    parameter int CODE_W  = $clog2(N_CODES),
    parameter int SETTLE  = CMP_SETTLE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [N_CODES-1:0]           match_set,
    output logic [CODE_W-1:0]            code_out,
    output logic                         code_valid,
    input  logic                         cmp_in,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [N_CODES-1:0]           hit_vec,
    output logic                         any_hit,
    output logic [CODE_W-1:0]            first_hit,
    output logic [$clog2(N_CODES+1)-1:0] err_cnt
);

    localparam int                ERR_W     = $clog2(N_CODES + 1);
    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(N_CODES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(N_CODES);

    scan_state_e        state_q,   state_d;
    logic [CODE_W-1:0]  code_q,    code_d;
    logic [N_CODES-1:0] match_q,   match_d;
    logic [N_CODES-1:0] hit_q,     hit_d;
    logic [ERR_W-1:0]   err_q,     err_d;
    logic               aborted_q, aborted_d;

    logic timer_load;
    logic timer_expire;

    cmp_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (state_q == DRIVE),
        .expire (timer_expire)
    );

    // Comparator contract: code_out is stable whenever code_valid is high, and
    // cmp_in is only trusted at the end of a SAMPLE cycle; there is no backpressure.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        match_d    = match_q;
        hit_d      = hit_q;
        err_d      = err_q;
        aborted_d  = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = DRIVE;
                    match_d    = match_set;
                    code_d     = '0;
                    hit_d      = '0;
                    err_d      = '0;
                    timer_load = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (timer_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // Abort takes priority, so this cycle's sample is dropped.
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    hit_d[code_q] = cmp_in;
                    if ((cmp_in != match_q[code_q]) && (err_q != ERR_MAX)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (code_q == LAST_CODE) begin
                        state_d = DONE;
                    end else begin
                        code_d     = code_q + CODE_W'(1);
                        timer_load = 1'b1;
                        state_d    = DRIVE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            match_q   <= '0;
            hit_q     <= '0;
            err_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            match_q   <= match_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        first_hit = '0;
        for (int i = N_CODES - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                first_hit = CODE_W'(i);
            end
        end
    end

    assign code_out   = code_q;
    assign code_valid = (state_q == DRIVE) || (state_q == SAMPLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign hit_vec    = hit_q;
    assign any_hit    = |hit_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Bench for cmp_scan_ctrl: a default build (4 codes, settle 2) and an 8-code,
// settle-1 build, both checked every cycle against a scan-timeline model.
module tb_cmp_scan_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i [2];
    logic       abort_i [2];
    logic [7:0] match_i [2];
    logic [7:0] cmp_tab [2];

    int tests = 0;
    int fails = 0;
    int fail_prints = 0;

    always #5 clk = ~clk;

    // default build
    logic [1:0] code0, first0;
    logic       cv0, busy0, done0, ab0, any0, cmp0;
    logic [3:0] hit0;
    logic [2:0] err0;
    assign cmp0 = cmp_tab[0][code0];

    cmp_scan_ctrl dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_i[0]),
        .abort      (abort_i[0]),
        .match_set  (match_i[0][3:0]),
        .code_out   (code0),
        .code_valid (cv0),
        .cmp_in     (cmp0),
        .busy       (busy0),
        .done       (done0),
        .aborted    (ab0),
        .hit_vec    (hit0),
        .any_hit    (any0),
        .first_hit  (first0),
        .err_cnt    (err0)
    );

    // 8-code, settle-1 build
    logic [2:0] code1, first1;
    logic       cv1, busy1, done1, ab1, any1, cmp1;
    logic [7:0] hit1;
    logic [3:0] err1;
    assign cmp1 = cmp_tab[1][code1];

    cmp_scan_ctrl #(.N_CODES(8), .SETTLE(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_i[1]),
        .abort      (abort_i[1]),
        .match_set  (match_i[1]),
        .code_out   (code1),
        .code_valid (cv1),
        .cmp_in     (cmp1),
        .busy       (busy1),
        .done       (done1),
        .aborted    (ab1),
        .hit_vec    (hit1),
        .any_hit    (any1),
        .first_hit  (first1),
        .err_cnt    (err1)
    );

    function automatic int nc(int u);
        return (u == 0) ? 4 : 8;
    endfunction

    function automatic int st(int u);
        return (u == 0) ? 2 : 1;
    endfunction

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    // A scan is a timeline: m_t counts busy cycles since the start was taken.
    // Cycles 0..len-1 belong to code t/(S+1), the last of each group is the
    // sample cycle, and cycle len is the done cycle.
    bit       m_act   [2];
    int       m_t     [2];
    bit [7:0] m_match [2];
    bit [7:0] m_hit   [2];
    int       m_err   [2];
    int       m_last  [2];
    bit       m_ab    [2];

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            int len;
            int c;
            len = nc(u) * (st(u) + 1);
            if (!rst_n) begin
                m_act[u] = 0; m_t[u] = 0; m_match[u] = '0; m_hit[u] = '0;
                m_err[u] = 0; m_last[u] = 0; m_ab[u] = 0;
            end else begin
                m_ab[u] = 0;
                if (m_act[u]) begin
                    if (m_t[u] == len) begin
                        m_act[u] = 0;
                    end else if (abort_i[u]) begin
                        m_act[u] = 0;
                        m_ab[u]  = 1;
                    end else begin
                        if ((m_t[u] % (st(u) + 1)) == st(u)) begin
                            c = m_t[u] / (st(u) + 1);
                            m_hit[u][c] = cmp_tab[u][c];
                            if (cmp_tab[u][c] != m_match[u][c]) m_err[u]++;
                        end
                        m_t[u]++;
                    end
                end else if (start_i[u] && !abort_i[u]) begin
                    m_act[u]   = 1;
                    m_t[u]     = 0;
                    m_match[u] = match_i[u] & 8'((1 << nc(u)) - 1);
                    m_hit[u]   = '0;
                    m_err[u]   = 0;
                end
                if (m_act[u] && (m_t[u] < len)) m_last[u] = m_t[u] / (st(u) + 1);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    task automatic check_unit(int u, int a_busy, int a_cv, int a_code, int a_done, int a_ab,
                              int a_hit, int a_any, int a_first, int a_err);
        int    len;
        int    e_first;
        string p;
        len = nc(u) * (st(u) + 1);
        e_first = 0;
        for (int i = nc(u) - 1; i >= 0; i--) if (m_hit[u][i]) e_first = i;
        p = (u == 0) ? "u0." : "u1.";
        check({p, "busy"},       a_busy,  int'(m_act[u]));
        check({p, "code_valid"}, a_cv,    int'(m_act[u] && (m_t[u] < len)));
        check({p, "code_out"},   a_code,  m_last[u]);
        check({p, "done"},       a_done,  int'(m_act[u] && (m_t[u] == len)));
        check({p, "aborted"},    a_ab,    int'(m_ab[u]));
        check({p, "hit_vec"},    a_hit,   int'(m_hit[u]));
        check({p, "any_hit"},    a_any,   int'(m_hit[u] != 0));
        check({p, "first_hit"},  a_first, e_first);
        check({p, "err_cnt"},    a_err,   m_err[u]);
    endtask

    initial forever begin
        @(negedge clk);
        check_unit(0, int'(busy0), int'(cv0), int'(code0), int'(done0), int'(ab0),
                   int'(hit0), int'(any0), int'(first0), int'(err0));
        check_unit(1, int'(busy1), int'(cv1), int'(code1), int'(done1), int'(ab1),
                   int'(hit1), int'(any1), int'(first1), int'(err1));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(int u);
        return (u == 0) ? done0 : done1;
    endfunction

    // lat = cycle index (relative to the start-sampling edge) in which done is seen
    task automatic run_scan(int u, logic [7:0] match, logic [7:0] tab, output int lat);
        cmp_tab[u] = tab;
        match_i[u] = match;
        start_i[u] = 1'b1;
        step();
        start_i[u] = 1'b0;
        lat = 1;
        while (!done_of(u) && (lat < 100)) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_code0(int code);
        int n;
        n = 0;
        while ((int'(code0) != code) && (n < 50)) begin
            step();
            n++;
        end
        check("wait_code_reached", int'(code0), code);
    endtask

    initial begin
        int lat;
        for (int u = 0; u < 2; u++) begin
            start_i[u] = 1'b0; abort_i[u] = 1'b0; match_i[u] = '0; cmp_tab[u] = '0;
        end
        repeat (3) step();

        check("rst.busy", int'(busy0), 0);
        check("rst.code_out", int'(code0), 0);
        check("rst.hit_vec", int'(hit0), 0);
        check("rst.err_cnt", int'(err0), 0);
        rst_n = 1'b1;
        step();

        // membership {1,2}, comparator agrees
        run_scan(0, 8'b0110, 8'b0110, lat);
        check("t1.latency", lat, 13);
        check("t1.hit_vec", int'(hit0), 4'b0110);
        check("t1.err_cnt", int'(err0), 0);
        check("t1.first_hit", int'(first0), 1);
        check("t1.any_hit", int'(any0), 1);
        step();

        // all expected, comparator never fires
        run_scan(0, 8'b1111, 8'b0000, lat);
        check("t2.latency", lat, 13);
        check("t2.hit_vec", int'(hit0), 0);
        check("t2.err_cnt", int'(err0), 4);
        check("t2.any_hit", int'(any0), 0);
        check("t2.first_hit", int'(first0), 0);
        step();

        // abort while code 2 is in DRIVE
        cmp_tab[0] = 8'hff;
        match_i[0] = 8'h00;
        start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        wait_code0(2);
        abort_i[0] = 1'b1;
        step();
        abort_i[0] = 1'b0;
        check("t3.aborted", int'(ab0), 1);
        check("t3.busy", int'(busy0), 0);
        check("t3.done", int'(done0), 0);
        check("t3.hit_vec", int'(hit0), 4'b0011);
        check("t3.err_cnt", int'(err0), 2);
        step();
        check("t3.aborted_one_cycle", int'(ab0), 0);

        // start while busy is ignored; start right after done is accepted
        cmp_tab[0] = 8'b0110;
        match_i[0] = 8'b0110;
        start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        lat = 1;
        repeat (4) begin step(); lat++; end
        start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        lat++;
        while (!done0 && (lat < 100)) begin step(); lat++; end
        check("t4.latency_ignored_start", lat, 13);
        step();
        check("t4.idle_after_done", int'(busy0), 0);
        run_scan(0, 8'b1001, 8'b0101, lat);
        check("t4.back_to_back_latency", lat, 13);
        check("t4.err_cnt", int'(err0), 2);

        // asynchronous reset mid-scan at code 3
        step();
        cmp_tab[0] = 8'b0110;
        match_i[0] = 8'b0110;
        start_i[0] = 1'b1;
        step();
        start_i[0] = 1'b0;
        wait_code0(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.code_out", int'(code0), 0);
        check("t5.busy", int'(busy0), 0);
        check("t5.code_valid", int'(cv0), 0);
        check("t5.hit_vec", int'(hit0), 0);
        check("t5.err_cnt", int'(err0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        run_scan(0, 8'b0110, 8'b0110, lat);
        check("t5.rescan_latency", lat, 13);
        check("t5.rescan_hit_vec", int'(hit0), 4'b0110);
        step();

        // 8 codes, settle 1
        cmp_tab[1] = 8'ha4;
        match_i[1] = 8'ha4;
        start_i[1] = 1'b1;
        step();
        start_i[1] = 1'b0;
        lat = 1;
        while (!done1 && (lat < 100)) begin
            if (lat <= 16) check("t6.code_step", int'(code1), (lat - 1) / 2);
            step();
            lat++;
        end
        check("t6.latency", lat, 17);
        check("t6.hit_vec", int'(hit1), 8'ha4);
        check("t6.err_cnt", int'(err1), 0);
        check("t6.first_hit", int'(first1), 2);
        step();

        // randomized scans with stray starts, aborts and start+abort collisions
        for (int it = 0; it < 60; it++) begin
            int  u;
            int  len;
            int  ab_at;
            bit  both;
            u   = $urandom_range(0, 1);
            len = nc(u) * (st(u) + 1);
            cmp_tab[u] = 8'($urandom);
            match_i[u] = 8'($urandom);
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : -1;
            both  = ($urandom_range(0, 7) == 0);
            start_i[u] = 1'b1;
            abort_i[u] = both;
            step();
            start_i[u] = 1'b0;
            abort_i[u] = 1'b0;
            for (int c = 1; c <= len + 1; c++) begin
                abort_i[u] = (c == ab_at);
                start_i[u] = ($urandom_range(0, 5) == 0);
                step();
            end
            start_i[u] = 1'b0;
            abort_i[u] = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (30) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmp_scan_ctrl.md
# cmp_scan_ctrl

Sequencer for the 2-bit-select comparator datapath. On `start` it steps the comparator's select code through every value 0..N_CODES-1 and waits a programmable settle time at each code. It then samples the comparator's 1-bit result and checks it against a requested membership set, i.e. "is code inside {set}". It reports the per-code hit vector, the lowest hit and a mismatch count. It sits between the test/config logic and the comparator, and is the only driver of the comparator select.

## Interface
Parameters:
- `N_CODES`, default 4: number of codes swept; must be a power of two, ≥ 2.
- `CODE_W`, default `$clog2(N_CODES)`: width of the code bus.
- `SETTLE`, default 2: cycles the code is held before sampling; ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a scan. Honoured only in IDLE.
- `abort`  in  1  cancel a scan in progress.
- `match_set`  in  N_CODES  expected-membership mask. Bit i = 1 means code i must match. Captured at start.
- `code_out`  out  CODE_W  select code driven to the comparator.
- `code_valid`  out  1  high while `code_out` is being driven (DRIVE/SAMPLE).
- `cmp_in`  in  1  comparator result for the current `code_out`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse: scan completed normally.
- `aborted`  out  1  one-cycle pulse: scan cancelled.
- `hit_vec`  out  N_CODES  sampled `cmp_in`, one bit per code.
- `any_hit`  out  1  OR of `hit_vec`.
- `first_hit`  out  CODE_W  lowest index set in `hit_vec`; 0 if none.
- `err_cnt`  out  `$clog2(N_CODES+1)`  number of codes where `cmp_in` ≠ `match_set` bit.

## Operation
States and transitions:
- IDLE:
  - `start` && !`abort` → DRIVE.
  - On that entry: latch `match_set`; code=0; settle counter=SETTLE; clear `hit_vec` and `err_cnt`.
- DRIVE:
  - Counter decrements each cycle.
  - When counter==1 → SAMPLE.
- SAMPLE (one cycle):
  - `hit_vec[code]` ← `cmp_in`.
  - If `cmp_in` ≠ latched `match_set[code]`: `err_cnt`++ (saturating; cannot overflow by construction).
  - If code==N_CODES-1 → DONE.
  - Otherwise code++, counter=SETTLE → DRIVE.
- DONE (one cycle): `done`=1 → IDLE.
- Abort: `abort` in DRIVE or SAMPLE → IDLE next edge.
  - `aborted`=1 for one cycle.
  - The sample in that cycle is discarded.
  - `hit_vec`/`err_cnt` keep their partial values; no `done`.

Output behaviour:
- `busy` = (state ≠ IDLE).
- `code_valid` = DRIVE or SAMPLE.
- `code_out` holds its last value in IDLE/DONE.
- `any_hit` and `first_hit` are combinational from `hit_vec`.
- `start` while busy is ignored, not queued.

Reset values: state IDLE; `code_out`=0; `code_valid`, `busy`, `done`, `aborted`=0; `hit_vec`=0; `err_cnt`=0. Reset mid-scan discards everything.

## Timing
- Start sampled at edge k: `busy`, `code_valid` high from k+1 with `code_out`=0.
- Each code occupies SETTLE+1 cycles: SETTLE in DRIVE, 1 in SAMPLE.
- `cmp_in` is sampled at the end of the SAMPLE cycle.
- `done` is high in cycle k+1+N_CODES·(SETTLE+1); with defaults that is k+13.
- Results are valid from the `done` cycle and stable until the next accepted `start`.
- `busy` is low in the cycle after `done`. A `start` in that cycle is accepted, giving back-to-back scans with one idle cycle.
- `start` and `abort` together in IDLE: abort wins, nothing starts, no `aborted` pulse.

## Structure
- Package `cmp_scan_pkg`:
  - `scan_state_e` enum {IDLE, DRIVE, SAMPLE, DONE}.
  - Default constants `CMP_N_CODES`=4 and `CMP_SETTLE`=2.
- One sub-module, `cmp_settle_timer`: loadable down-counter of width `$clog2(SETTLE+1)` with `load`, `expire` (count==1) outputs.
- The priority encoder for `first_hit` stays inline.

## Test plan
- Defaults, `match_set`=4'b0110, comparator model asserts `cmp_in` for codes 1,2 → `done` at k+13, `hit_vec`=0110, `err_cnt`=0, `first_hit`=1, `any_hit`=1.
- `match_set`=4'b1111, `cmp_in` tied 0 → `hit_vec`=0000, `err_cnt`=4, `any_hit`=0, `first_hit`=0.
- `abort` while `code_out`=2 in DRIVE → `aborted` pulse next cycle, no `done`, `busy`=0, `hit_vec` bits 0–1 only.
- `start` pulsed during a busy scan, then again in the cycle after `done` → first ignored; second scan's `done` arrives 13 cycles after it.
- `rst_n` low mid-scan at `code_out`=3 → all outputs at reset values asynchronously; next `start` scans cleanly from code 0.
- SETTLE=1, N_CODES=8 build → `done` 17 cycles after `start`; `code_out` steps 0..7 every 2 cycles.
